// File: rtl/alu_pkg.sv
// Shared definitions for the ALU opcode interface: RV64 opcode fields, ALU opcode
// classes and the layout of one decoded entry.
package alu_pkg;

    localparam int OPC_W      = 10;
    localparam int RD_W       = 5;
    localparam int ALU_DATA_W = 64;

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_RI   = 2'b01;
    localparam logic [1:0] CLS_RR   = 2'b10;
    localparam logic [1:0] CLS_SUB  = 2'b11;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_DWORD = 3'b011;
    localparam logic [2:0] F3_XOR   = 3'b100;
    localparam logic [2:0] F3_SRL   = 3'b101;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU opcode layout is {class, 5'b0, funct3}
    function automatic logic [OPC_W-1:0] make_opcode(input logic [1:0] cls, input logic [2:0] f3);
        return {cls, 5'b00000, f3};
    endfunction

    localparam logic [OPC_W-1:0] ALU_ADD  = {CLS_RR,  5'b00000, F3_ADD};
    localparam logic [OPC_W-1:0] ALU_XOR  = {CLS_RR,  5'b00000, F3_XOR};
    localparam logic [OPC_W-1:0] ALU_OR   = {CLS_RR,  5'b00000, F3_OR};
    localparam logic [OPC_W-1:0] ALU_AND  = {CLS_RR,  5'b00000, F3_AND};
    localparam logic [OPC_W-1:0] ALU_SLL  = {CLS_RI,  5'b00000, F3_SLL};
    localparam logic [OPC_W-1:0] ALU_SRL  = {CLS_RI,  5'b00000, F3_SRL};
    localparam logic [OPC_W-1:0] ALU_ADDR = {CLS_RI,  5'b00000, F3_ADD};
    localparam logic [OPC_W-1:0] ALU_SUB  = {CLS_SUB, 5'b00000, F3_ADD};

    typedef struct packed {
        logic [OPC_W-1:0]      opcode;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic [RD_W-1:0]       rd;
        logic                  we;
        logic                  illegal;
    } alu_entry_t;

    function automatic int entry_width(input int data_w);
        return OPC_W + 2 * data_w + RD_W + 2;
    endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic two-entry valid/ready register stage. in_ready depends on registers only,
// so the upstream handshake never sees a combinational path from out_ready.
module alu_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q,  main_data_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         push;
    logic         pop;

    assign push = in_valid & ~skid_valid_q;
    assign pop  = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            // A full skid implies in_ready was low, so no push can coincide with the refill
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (push) begin
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (push) begin
            if (main_valid_q) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end else begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/alu_op_decoder.sv
// Decodes an RV64 instruction plus register operands into an ALU {opcode, a, b} entry
// and hands it downstream through a two-entry valid/ready buffer.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [DATA_W-1:0]    in_rs1_data,
    input  logic [DATA_W-1:0]    in_rs2_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPC_W-1:0]     out_opcode,
    output logic [DATA_W-1:0]    out_a,
    output logic [DATA_W-1:0]    out_b,
    output logic [RD_W-1:0]      out_rd,
    output logic                 out_we,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [RD_W-1:0]   rd;
        logic              we;
        logic              illegal;
    } entry_t;

    localparam int ENTRY_W = entry_width(DATA_W);

    logic [6:0]           rv_opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [RD_W-1:0]      rd_field;
    logic [DATA_W-1:0]    imm_i;
    logic [DATA_W-1:0]    imm_s;
    logic [DATA_W-1:0]    shamt;
    logic                 unused_rs1_field;

    logic                 legal;
    logic                 is_store;
    logic [OPC_W-1:0]     dec_opcode;
    logic [DATA_W-1:0]    dec_b;
    entry_t               dec_entry;

    logic [ENTRY_W-1:0]   buf_out_data;
    entry_t               out_entry;
    logic                 accept;
    logic [ILL_CNT_W-1:0] ill_count_q, ill_count_d;

    assign rv_opcode        = in_inst[6:0];
    assign funct3           = in_inst[14:12];
    assign funct7           = in_inst[31:25];
    assign rd_field         = in_inst[11:7];
    assign imm_i            = {{(DATA_W-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_s            = {{(DATA_W-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign shamt            = {{(DATA_W-6){1'b0}}, in_inst[25:20]};
    assign unused_rs1_field = ^in_inst[19:15];

    always_comb begin
        legal      = 1'b0;
        is_store   = 1'b0;
        dec_opcode = '0;
        dec_b      = '0;
        unique case (rv_opcode)
            OP_IMM: begin
                unique case (funct3)
                    F3_ADD, F3_XOR, F3_OR, F3_AND: begin
                        legal      = 1'b1;
                        dec_opcode = make_opcode(CLS_RI, funct3);
                        dec_b      = imm_i;
                    end
                    // RV64 shifts carry a 6-bit shamt; the upper bits must be zero
                    F3_SLL, F3_SRL: begin
                        legal      = (in_inst[31:26] == 6'b000000);
                        dec_opcode = make_opcode(CLS_RI, funct3);
                        dec_b      = shamt;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP: begin
                dec_b = in_rs2_data;
                if (funct7 == F7_BASE && (funct3 == F3_ADD || funct3 == F3_XOR ||
                                          funct3 == F3_OR  || funct3 == F3_AND)) begin
                    legal      = 1'b1;
                    dec_opcode = make_opcode(CLS_RR, funct3);
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    legal      = 1'b1;
                    dec_opcode = ALU_SUB;
                end
            end
            OP_LOAD: begin
                legal      = (funct3 == F3_DWORD);
                dec_opcode = ALU_ADDR;
                dec_b      = imm_i;
            end
            OP_STORE: begin
                legal      = (funct3 == F3_DWORD);
                is_store   = 1'b1;
                dec_opcode = ALU_ADDR;
                dec_b      = imm_s;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_entry    = '0;
        dec_entry.rd = rd_field;
        if (legal) begin
            dec_entry.opcode = dec_opcode;
            dec_entry.a      = in_rs1_data;
            dec_entry.b      = dec_b;
            dec_entry.we     = ~is_store & (rd_field != '0);
        end else begin
            dec_entry.illegal = 1'b1;
        end
    end

    alu_skid_buffer #(
        .W (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out_data)
    );

    assign out_entry   = buf_out_data;
    assign out_opcode  = out_entry.opcode;
    assign out_a       = out_entry.a;
    assign out_b       = out_entry.b;
    assign out_rd      = out_entry.rd;
    assign out_we      = out_entry.we;
    assign out_illegal = out_entry.illegal;

    // A flushed input is dropped, so it must not be counted either
    assign accept = in_valid & in_ready & ~flush;

    always_comb begin
        ill_count_d = ill_count_q;
        if (accept && dec_entry.illegal && ill_count_q != '1) begin
            ill_count_d = ill_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ill_count_q <= '0;
        end else begin
            ill_count_q <= ill_count_d;
        end
    end

    assign ill_count = ill_count_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed checks of alu_op_decoder: decode results, skid-buffer ordering under
// back-pressure, illegal counter saturation, flush and mid-stream reset.
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_rs1_data;
    logic [63:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_opcode;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;
    logic [15:0] ill_count;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] INST_BEQ = 32'h00208063;

    always #5 clk = ~clk;

    alu_op_decoder #(
        .DATA_W    (64),
        .ILL_CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_illegal (out_illegal),
        .ill_count   (ill_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] rs1, input logic [63:0] rs2);
        in_valid    = v;
        in_inst     = inst;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
    endtask

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fails++;
            $display("[TB] FAIL reset_handshake: got %b expected 01", {out_valid, in_ready});
        end
        n_checks++;
        if ({out_opcode, out_a, out_b, out_rd, out_we, out_illegal, ill_count} !== '0) begin
            n_fails++;
            $display("[TB] FAIL reset_fields: got %h expected 0",
                     {out_opcode, out_a, out_b, out_rd, out_we, out_illegal, ill_count});
        end
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF08293, 64'd10, 64'd99);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        n_checks++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd, out_we, out_illegal} !==
            {1'b1, 10'b0100000000, 64'd10, {64{1'b1}}, 5'd5, 1'b1, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL addi_entry: got %h expected %h",
                     {out_valid, out_opcode, out_a, out_b, out_rd, out_we, out_illegal},
                     {1'b1, 10'b0100000000, 64'd10, {64{1'b1}}, 5'd5, 1'b1, 1'b0});
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL addi_drained: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_sub_slli();
        out_ready = 1'b1;
        drive(1'b1, 32'h401101B3, 64'd20, 64'd7);
        tick();
        n_checks++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd, out_we, out_illegal} !==
            {1'b1, 10'b1100000000, 64'd20, 64'd7, 5'd3, 1'b1, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL sub_entry: got %h expected %h",
                     {out_valid, out_opcode, out_a, out_b, out_rd, out_we, out_illegal},
                     {1'b1, 10'b1100000000, 64'd20, 64'd7, 5'd3, 1'b1, 1'b0});
        end
        drive(1'b1, 32'h03F09093, 64'h8000_0000_0000_0001, 64'd0);
        tick();
        n_checks++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd, out_we, out_illegal} !==
            {1'b1, 10'b0100000001, 64'h8000_0000_0000_0001, 64'd63, 5'd1, 1'b1, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL slli_entry: got %h expected %h",
                     {out_valid, out_opcode, out_a, out_b, out_rd, out_we, out_illegal},
                     {1'b1, 10'b0100000001, 64'h8000_0000_0000_0001, 64'd63, 5'd1, 1'b1, 1'b0});
        end
        drive(1'b1, 32'h04009093, 64'd5, 64'd0);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        n_checks++;
        if ({out_valid, out_opcode, out_a, out_b, out_we, out_illegal} !==
            {1'b1, 10'd0, 64'd0, 64'd0, 1'b0, 1'b1}) begin
            n_fails++;
            $display("[TB] FAIL slli_shamt64_illegal: got %h expected %h",
                     {out_valid, out_opcode, out_a, out_b, out_we, out_illegal},
                     {1'b1, 10'd0, 64'd0, 64'd0, 1'b0, 1'b1});
        end
        n_checks++;
        if (ill_count !== 16'd1) begin
            n_fails++;
            $display("[TB] FAIL slli_ill_count: got %0d expected 1", ill_count);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [31:0] insts [4];
        int   sent;
        int   got;
        logic acc;
        sent = 0;
        got  = 0;
        for (int k = 0; k < 4; k++) insts[k] = enc_addi(5'(k + 10), 12'(k + 1));
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            out_ready = (cyc >= 3);
            if (sent < 4) drive(1'b1, insts[sent], 64'(100 + sent), 64'd0);
            else          drive(1'b0, 32'd0, 64'd0, 64'd0);
            if (cyc == 2) begin
                n_checks++;
                if ({in_ready, out_valid, out_a} !== {1'b0, 1'b1, 64'd100}) begin
                    n_fails++;
                    $display("[TB] FAIL bp_full_hold: got %h expected %h",
                             {in_ready, out_valid, out_a}, {1'b0, 1'b1, 64'd100});
                end
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                n_checks++;
                if ({out_opcode, out_a, out_b, out_rd} !==
                    {10'b0100000000, 64'(100 + got), 64'(got + 1), 5'(got + 10)}) begin
                    n_fails++;
                    $display("[TB] FAIL bp_order_%0d: got %h expected %h", got,
                             {out_opcode, out_a, out_b, out_rd},
                             {10'b0100000000, 64'(100 + got), 64'(got + 1), 5'(got + 10)});
                end
                got++;
            end
            tick();
            if (acc) sent++;
        end
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        n_checks++;
        if (sent != 4 || got != 4) begin
            n_fails++;
            $display("[TB] FAIL bp_count: got sent=%0d popped=%0d expected 4/4", sent, got);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL bp_no_duplicate: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_store_illegal();
        int acc_total;
        logic acc;
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h0020B423, 64'h1000, 64'h55);
        tick();
        n_checks++;
        if ({out_valid, out_opcode, out_a, out_b, out_we, out_illegal} !==
            {1'b1, 10'b0100000000, 64'h1000, 64'd8, 1'b0, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL sd_entry: got %h expected %h",
                     {out_valid, out_opcode, out_a, out_b, out_we, out_illegal},
                     {1'b1, 10'b0100000000, 64'h1000, 64'd8, 1'b0, 1'b0});
        end
        drive(1'b1, INST_BEQ, 64'd3, 64'd4);
        tick();
        n_checks++;
        if ({out_valid, out_opcode, out_a, out_b, out_we, out_illegal, ill_count} !==
            {1'b1, 10'd0, 64'd0, 64'd0, 1'b0, 1'b1, 16'd1}) begin
            n_fails++;
            $display("[TB] FAIL beq_illegal: got %h expected %h",
                     {out_valid, out_opcode, out_a, out_b, out_we, out_illegal, ill_count},
                     {1'b1, 10'd0, 64'd0, 64'd0, 1'b0, 1'b1, 16'd1});
        end
        acc_total = 1;
        for (int cyc = 0; cyc < 70000 && acc_total < 65539; cyc++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                acc_total++;
                if (acc_total == 65534) begin
                    n_checks++;
                    if (ill_count !== 16'hFFFE) begin
                        n_fails++;
                        $display("[TB] FAIL ill_count_near_sat: got %h expected fffe", ill_count);
                    end
                end
            end
        end
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        n_checks++;
        if (acc_total != 65539 || ill_count !== 16'hFFFF) begin
            n_fails++;
            $display("[TB] FAIL ill_count_saturate: got %h after %0d accepts expected ffff after 65539",
                     ill_count, acc_total);
        end
        tick();
    endtask

    task automatic test_flush();
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, enc_addi(5'd4, 12'd1), 64'd1, 64'd0);
        tick();
        drive(1'b1, enc_addi(5'd6, 12'd2), 64'd2, 64'd0);
        tick();
        flush = 1'b1;
        drive(1'b1, INST_BEQ, 64'd0, 64'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        n_checks++;
        if ({out_valid, in_ready, ill_count} !== {1'b0, 1'b1, 16'd0}) begin
            n_fails++;
            $display("[TB] FAIL flush_full: got %h expected %h",
                     {out_valid, in_ready, ill_count}, {1'b0, 1'b1, 16'd0});
        end
        drive(1'b1, enc_addi(5'd7, 12'd3), 64'd3, 64'd0);
        tick();
        flush = 1'b1;
        drive(1'b1, INST_BEQ, 64'd0, 64'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        n_checks++;
        if ({out_valid, in_ready, ill_count} !== {1'b0, 1'b1, 16'd0}) begin
            n_fails++;
            $display("[TB] FAIL flush_drop_input: got %h expected %h",
                     {out_valid, in_ready, ill_count}, {1'b0, 1'b1, 16'd0});
        end
        out_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL flush_nothing_emitted: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(1'b1, enc_addi(5'd7, 12'd5), 64'd1, 64'd0);
        tick();
        drive(1'b1, INST_BEQ, 64'd0, 64'd0);
        tick();
        out_ready = 1'b0;
        drive(1'b1, enc_addi(5'd8, 12'd6), 64'd2, 64'd0);
        tick();
        rst = 1'b1; flush = 1'b1;
        drive(1'b1, INST_BEQ, 64'd0, 64'd0);
        tick();
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        n_checks++;
        if ({out_valid, in_ready, out_opcode, out_a, out_b, out_rd, out_we, out_illegal, ill_count} !==
            {1'b0, 1'b1, 10'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 16'd0}) begin
            n_fails++;
            $display("[TB] FAIL midreset_state: got %h expected %h",
                     {out_valid, in_ready, out_opcode, out_a, out_b, out_rd, out_we, out_illegal, ill_count},
                     {1'b0, 1'b1, 10'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 16'd0});
        end
        out_ready = 1'b1;
        drive(1'b1, enc_addi(5'd9, 12'd3), 64'd40, 64'd0);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        n_checks++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd, out_we, out_illegal} !==
            {1'b1, 10'b0100000000, 64'd40, 64'd3, 5'd9, 1'b1, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL midreset_resume: got %h expected %h",
                     {out_valid, out_opcode, out_a, out_b, out_rd, out_we, out_illegal},
                     {1'b1, 10'b0100000000, 64'd40, 64'd3, 5'd9, 1'b1, 1'b0});
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL midreset_drained: out_valid got %b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_slli();
        test_back_pressure();
        test_store_illegal();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
